// File: rtl/lc3_step_pkg.sv
// Shared types for the LC-3 Run/Continue step sequencer.
// Sequencer states and the minimum gap length.
package lc3_step_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN_P,
    GAP,
    CONT_P,
    DONE
  } step_state_t;

  localparam int MIN_GAP = 1;

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter timing both pulse widths and gaps.
// Holds at zero once it runs out.
module step_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         expired
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign expired = (value == '0);

endmodule

// File: rtl/lc3_step_sequencer.sv
// Issues one active-low Run pulse, then Continue pulses
// separated by a programmable gap, for the LC-3 top level.
module lc3_step_sequencer
  import lc3_step_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int STEP_W       = 8,
  parameter int PULSE_CYCLES = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic              mode,
  input  logic [STEP_W-1:0] num_steps,
  input  logic [CNT_W-1:0]  gap_cycles,
  input  logic              stop,
  output logic              Run,
  output logic              Continue,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] step_count
);

  localparam logic [CNT_W-1:0] PULSE_LD =
    CNT_W'(PULSE_CYCLES - 1);

  step_state_t       state;
  step_state_t       state_n;
  logic              mode_q;
  logic [STEP_W-1:0] steps_q;
  logic [CNT_W-1:0]  gap_q;
  logic              stop_seen;
  logic              stop_hit;
  logic [STEP_W-1:0] steps_int;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_ld_val;
  logic [CNT_W-1:0]  tmr_value;
  logic              tmr_exp;
  logic              last_step;

  step_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk      (Clk),
    .rst      (Reset),
    .load     (tmr_load),
    .load_val (tmr_ld_val),
    .value    (tmr_value),
    .expired  (tmr_exp)
  );

  // A stop arriving on the expiry edge itself still counts.
  assign stop_hit  = stop_seen | stop;
  assign last_step = !mode_q && (steps_int == steps_q);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (start) state_n = RUN_P;
      RUN_P:  if (tmr_exp) state_n = GAP;
      GAP: begin
        if (tmr_exp) begin
          if (stop_hit || last_step) state_n = DONE;
          else                       state_n = CONT_P;
        end
      end
      CONT_P: if (tmr_exp) state_n = GAP;
      DONE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    tmr_load   = 1'b0;
    tmr_ld_val = PULSE_LD;
    if (state_n != state) begin
      unique case (1'b1)
        (state_n == RUN_P),
        (state_n == CONT_P): begin
          tmr_load   = 1'b1;
          tmr_ld_val = PULSE_LD;
        end
        (state_n == GAP): begin
          tmr_load   = 1'b1;
          tmr_ld_val = gap_q - 1'b1;
        end
        default: tmr_load = 1'b0;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      steps_q   <= '0;
      gap_q     <= '0;
      stop_seen <= 1'b0;
      steps_int <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        stop_seen <= 1'b0;
        if (start) begin
          mode_q    <= mode;
          steps_q   <= num_steps;
          gap_q     <= (gap_cycles == '0) ?
                       CNT_W'(MIN_GAP) : gap_cycles;
          steps_int <= '0;
        end
      end else begin
        stop_seen <= stop_hit;
      end
      if (state == CONT_P && tmr_exp && steps_int != '1) begin
        steps_int <= steps_int + 1'b1;
      end
    end
  end

  // Outputs are decoded from the settled state one edge later,
  // so every output is a clean flop.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Run        <= 1'b1;
      Continue   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      step_count <= '0;
    end else begin
      Run        <= (state != RUN_P);
      Continue   <= (state != CONT_P);
      busy       <= (state != IDLE);
      done       <= (state == DONE);
      step_count <= steps_int;
    end
  end

  a_excl: assert property (
    @(posedge Clk) disable iff (Reset) (Run || Continue)
  );

  a_idle_tmr: assert property (
    @(posedge Clk) disable iff (Reset)
      (state == IDLE) |-> (tmr_value == '0)
  );

endmodule

// File: tb/tb_lc3_step_sequencer.sv
// Checks the step sequencer against a pulse-train model built
// directly from the timing rules, on two parameterisations.
module tb_lc3_step_sequencer;

  localparam int BIG = 1 << 30;

  typedef struct {
    int run;
    int cont;
    int busy;
    int done;
    int cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        mode = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  nsteps = '0;
  logic [15:0] gap = '0;

  logic       run_a, cont_a, busy_a, done_a;
  logic [7:0] cnt_a;
  logic       run_b, cont_b, busy_b, done_b;
  logic [1:0] cnt_b;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lc3_step_sequencer u_a (
    .Clk        (clk),
    .Reset      (rst),
    .start      (start_a),
    .mode       (mode),
    .num_steps  (nsteps),
    .gap_cycles (gap),
    .stop       (stop),
    .Run        (run_a),
    .Continue   (cont_a),
    .busy       (busy_a),
    .done       (done_a),
    .step_count (cnt_a)
  );

  lc3_step_sequencer #(
    .STEP_W       (2),
    .PULSE_CYCLES (2)
  ) u_b (
    .Clk        (clk),
    .Reset      (rst),
    .start      (start_b),
    .mode       (mode),
    .num_steps  (nsteps[1:0]),
    .gap_cycles (gap),
    .stop       (stop),
    .Run        (run_b),
    .Continue   (cont_b),
    .busy       (busy_b),
    .done       (done_b),
    .step_count (cnt_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic set_start(input int which, input bit v);
    if (which == 0) start_a = v;
    else            start_b = v;
  endtask

  // Expected trace: cycle k (after edge k, start at edge 0).
  task automatic run_seq(input int which, input bit m,
                         input int n, input int g,
                         input int stop_edge,
                         input int restart_edge,
                         output int done_at,
                         output int n_cont,
                         output int last_cnt);
    exp_t q[$];
    int p, ge, maxc, cnt, l;
    bit fin;
    logic o_run, o_cont, o_busy, o_done;
    logic [7:0] o_cnt;
    logic prev_cont;
    p    = (which == 0) ? 1 : 2;
    maxc = (which == 0) ? 255 : 3;
    ge   = (g == 0) ? 1 : g;
    cnt  = 0;
    repeat (p) q.push_back('{0, 1, 1, 0, 0});
    fin = 1'b0;
    while (!fin) begin
      repeat (ge) q.push_back('{1, 1, 1, 0, cnt});
      l = q.size();
      if (stop_edge <= l || (!m && cnt == n) || l > 3000) begin
        q.push_back('{1, 1, 1, 1, cnt});
        fin = 1'b1;
      end else begin
        repeat (p) q.push_back('{1, 0, 1, 0, cnt});
        if (cnt < maxc) cnt++;
      end
    end
    q.push_back('{1, 1, 0, 0, cnt});

    @(negedge clk);
    mode   = m;
    nsteps = 8'(n);
    gap    = 16'(g);
    stop   = (stop_edge <= 0);
    set_start(which, 1'b1);
    @(negedge clk);
    stop = (stop_edge <= 1);
    set_start(which, restart_edge == 1);
    done_at   = -1;
    n_cont    = 0;
    last_cnt  = 0;
    prev_cont = 1'b1;
    for (int k = 1; k <= q.size(); k++) begin
      @(negedge clk);
      if (which == 0) begin
        o_run = run_a; o_cont = cont_a; o_busy = busy_a;
        o_done = done_a; o_cnt = cnt_a;
      end else begin
        o_run = run_b; o_cont = cont_b; o_busy = busy_b;
        o_done = done_b; o_cnt = {6'd0, cnt_b};
      end
      chk($sformatf("run@%0d", k), 32'(o_run), q[k-1].run);
      chk($sformatf("cont@%0d", k), 32'(o_cont), q[k-1].cont);
      chk($sformatf("busy@%0d", k), 32'(o_busy), q[k-1].busy);
      chk($sformatf("done@%0d", k), 32'(o_done), q[k-1].done);
      chk($sformatf("cnt@%0d", k), 32'(o_cnt), q[k-1].cnt);
      if (o_done && done_at < 0) done_at = k;
      if (!o_cont && prev_cont) n_cont++;
      prev_cont = o_cont;
      last_cnt  = int'(o_cnt);
      stop = (stop_edge <= k + 1);
      set_start(which, restart_edge == k + 1);
    end
    stop = 1'b0;
    set_start(which, 1'b0);
  endtask

  initial begin
    int d, c, s;
    int w, n, g, se;
    bit m;

    #1 rst = 1'b1;
    #1;
    chk("rst_run_a", 32'(run_a), 1);
    chk("rst_cont_a", 32'(cont_a), 1);
    chk("rst_busy_a", 32'(busy_a), 0);
    chk("rst_done_a", 32'(done_a), 0);
    chk("rst_cnt_a", 32'(cnt_a), 0);
    chk("rst_cnt_b", 32'(cnt_b), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Long fixed sequence on default parameters.
    run_seq(0, 1'b0, 9, 10, BIG, 0, d, c, s);
    chk("t1_len", d, 111);
    chk("t1_conts", c, 9);
    chk("t1_cnt", s, 9);

    // Zero steps, zero gap clamps to one.
    run_seq(0, 1'b0, 0, 0, BIG, 0, d, c, s);
    chk("t2_len", d, 3);
    chk("t2_conts", c, 0);

    // Stop mid second pulse, two-cycle pulses.
    run_seq(1, 1'b1, 0, 3, 12, 0, d, c, s);
    chk("t3_len", d, 16);
    chk("t3_conts", c, 2);
    chk("t3_cnt", s, 2);

    // Start while busy is ignored.
    run_seq(0, 1'b0, 9, 10, BIG, 46, d, c, s);
    chk("t4_len", d, 111);
    chk("t4_cnt", s, 9);

    // Async reset in the middle of a Continue pulse.
    @(negedge clk);
    mode = 1'b0; nsteps = 8'd9; gap = 16'd3; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 50 && cont_a; i++) @(negedge clk);
    chk("t5_cont_low", 32'(cont_a), 0);
    #2 rst = 1'b1;
    #1;
    chk("t5_cont", 32'(cont_a), 1);
    chk("t5_busy", 32'(busy_a), 0);
    chk("t5_run", 32'(run_a), 1);
    chk("t5_cnt", 32'(cnt_a), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_seq(0, 1'b0, 2, 2, BIG, 0, d, c, s);
    chk("t5_len", d, 10);

    // Counter saturation with a 2-bit step count.
    run_seq(1, 1'b1, 0, 1, 16, 0, d, c, s);
    chk("t6_conts", c, 5);
    chk("t6_cnt", s, 3);
    chk("t6_len", d, 19);

    for (int it = 0; it < 40; it++) begin
      w = int'($urandom_range(0, 1));
      m = 1'($urandom_range(0, 1));
      n = (w == 0) ? int'($urandom_range(0, 8))
                   : int'($urandom_range(0, 3));
      g = int'($urandom_range(0, 5));
      if (m) se = int'($urandom_range(0, 40));
      else se = $urandom_range(0, 1) ?
                int'($urandom_range(1, 40)) : BIG;
      run_seq(w, m, n, g, se, 0, d, c, s);
      if (!m && se == BIG) begin
        chk("rnd_len", d,
            (n + 1) * ((w == 0 ? 1 : 2) + (g == 0 ? 1 : g)) + 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
